// File: rtl/uart_rx_frontend_pkg.sv
// rtl/uart_rx_frontend_pkg.sv - shared UART state encoding and bit-timing helper
package uart_rx_frontend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_t;

  localparam int MIN_CLKS_PER_BIT = 4;

  // Shared with the transmitter so both ends derive identical bit periods.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_frontend_sync_2ff.sv
// rtl/uart_rx_frontend_sync_2ff.sv - two-flop synchronizer with selectable reset level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - oversampled UART receiver producing byte strobes
// with start-glitch rejection, framing-error pulses and break recovery.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int N_BITS    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  output logic [N_BITS-1:0] o_char_out,
  output logic              o_char_valid,
  output logic              o_framing_err,
  output logic              o_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(N_BITS) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_BITS - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_baud
    $error("uart_rx_frontend: CLKS_PER_BIT must be at least 4");
  end

  logic w_rx_s;

  uart_state_t       r_state;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [N_BITS-1:0] r_shift;
  logic [N_BITS-1:0] r_char_out;
  logic              r_char_valid;
  logic              r_framing_err;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_char_out    <= '0;
      r_char_valid  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_char_valid  <= 1'b0;
      r_framing_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (!w_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          // Re-check at mid start bit so short low glitches never open a frame.
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx_s, r_shift[N_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == IDX_LAST) r_state <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_char_out   <= r_shift;
              r_char_valid <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_framing_err <= 1'b1;
              r_state       <= ST_WAIT_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // Line must stay high a full bit period before we trust it again.
          if (!w_rx_s) begin
            r_clk_cnt <= '0;
          end else if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign o_char_out    = r_char_out;
  assign o_char_valid  = r_char_valid;
  assign o_framing_err = r_framing_err;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - directed scoreboard bench for uart_rx_frontend
module tb_uart_rx_frontend;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] char_out;
  logic       char_valid;
  logic       framing_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  logic [7:0] exp_q[$];
  int valid_cyc[$];

  uart_rx_frontend #(.CLK_FREQ(16), .BAUD_RATE(1), .N_BITS(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx          (rx),
    .o_char_out    (char_out),
    .o_char_valid  (char_valid),
    .o_framing_err (framing_err),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid || framing_err)
        check("valid_ferr_exclusive", {31'd0, char_valid & framing_err}, 32'd0);
      if (char_valid) begin
        n_valid++;
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_char", 32'd1, 32'd0);
        else check("char_out", {24'd0, char_out}, {24'd0, exp_q.pop_front()});
      end
      if (framing_err) n_ferr++;
    end
  end

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic push);
    if (push) exp_q.push_back(d);
    hold_rx(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_rx(d[i], CPB);
    hold_rx(stop, CPB);
  endtask

  initial begin
    int c0, vb, fb, d;
    logic [7:0] rb;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_char_out", {24'd0, char_out}, 32'd0);
    check("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check("rst_framing_err", {31'd0, framing_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    hold_rx(1'b1, 4);

    // 1: single 0x55 frame
    c0 = cyc;
    send_frame(8'h55, 1'b1, 1'b1);
    check("t1_count", n_valid, 1);
    d = valid_cyc[0] - c0;
    check("t1_latency_window", {31'd0, (d >= 154 && d <= 157)}, 32'd1);
    check("t1_no_ferr", n_ferr, 0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: back-to-back 0x00 then 0xFF, no idle gap
    vb = n_valid;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    hold_rx(1'b1, CPB);
    check("t2_count", n_valid, vb + 2);
    d = valid_cyc[vb + 1] - valid_cyc[vb];
    check("t2_spacing", {31'd0, (d >= 159 && d <= 161)}, 32'd1);

    // 3: start-bit glitch rejected, then normal frames
    vb = n_valid;
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 20);
    check("t3_glitch_no_char", n_valid, vb);
    check("t3_glitch_no_ferr", n_ferr, 0);
    check("t3_glitch_idle", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    hold_rx(1'b1, CPB);
    check("t3_count", n_valid, vb + 2);

    // 4: bad stop bit, line held low, recovery
    vb = n_valid;
    fb = n_ferr;
    send_frame(8'hA5, 1'b0, 1'b0);
    hold_rx(1'b0, 40);
    check("t4_ferr_once", n_ferr, fb + 1);
    check("t4_no_char", n_valid, vb);
    check("t4_char_held", {24'd0, char_out}, 32'h81);
    check("t4_busy_waiting", {31'd0, busy}, 32'd1);
    hold_rx(1'b1, 16);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold_rx(1'b1, CPB);
    check("t4_recovered", n_valid, vb + 1);
    check("t4_ferr_total", n_ferr, fb + 1);

    // 5: asynchronous reset in data bit 3 of 0x7E
    vb = n_valid;
    rb = 8'h7E;
    hold_rx(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold_rx(rb[i], CPB);
    hold_rx(rb[3], CPB / 2);
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_char_out", {24'd0, char_out}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_valid", {31'd0, char_valid}, 32'd0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_rx(1'b1, 20);
    check("t5_no_partial", n_valid, vb);
    send_frame(8'h7E, 1'b1, 1'b1);
    hold_rx(1'b1, CPB);
    check("t5_single", n_valid, vb + 1);

    // random back-to-back frames
    vb = n_valid;
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    hold_rx(1'b1, 2 * CPB);
    check("rand_count", n_valid, vb + 4);

    check("queue_drained", exp_q.size(), 0);
    check("ferr_total", n_ferr, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- UART receiver that sits directly upstream of the pattern-search FSM.
- Turns the asynchronous serial pin into byte strobes (char_out/char_valid) that the FSM consumes one-for-one.
- Frame format is 8N1 by default: oversampled by the system clock, bits sampled at mid-bit, LSB first.
- Flags framing errors and rejects start-bit glitches, so the downstream matcher never sees phantom characters.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- N_BITS, 8, data bits per frame; must equal the consumer's N_BITS.
- Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 217 at defaults). Elaboration must fail if CLKS_PER_BIT < 4.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx  in  1  serial input pin; asynchronous to clk; idle high.
- char_out  out  N_BITS  last received data byte; held until the next good frame.
- char_valid  out  1  one-cycle pulse; char_out is valid in that cycle.
- framing_err  out  1  one-cycle pulse when the stop bit samples low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - char_out=0, char_valid=0, framing_err=0, busy=0.
  - Synchronizer flops are set to 1 (idle line).
  - FSM goes to IDLE; all counters are cleared.
- Input sync: rx passes through a 2-FF synchronizer and the FSM sees only rx_s. There is 2 cycles of added latency.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits wide.
  - bit_idx is $clog2(N_BITS) bits wide when N_BITS is not a power of two. Use $clog2(N_BITS)+1 bits in general, to avoid wrap ambiguity.
- FSM states:
  - IDLE: busy=0, clk_cnt=0. On rx_s==0, go to START.
  - START:
    - Count to CLKS_PER_BIT/2-1, then resample.
    - If rx_s==0, clear clk_cnt and go to DATA.
    - If rx_s==1, it was a glitch: go to IDLE with no output.
  - DATA:
    - Count to CLKS_PER_BIT-1, then shift rx_s into the MSB of the shift register (LSB-first frame) and increment bit_idx.
    - After N_BITS samples, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - rx_s==1: next cycle char_out<=shift register and char_valid=1 for exactly 1 cycle; go to IDLE.
    - rx_s==0: next cycle framing_err=1 for 1 cycle; char_out is unchanged; go to WAIT_IDLE.
  - WAIT_IDLE:
    - Stay until rx_s has been high for CLKS_PER_BIT consecutive cycles, then go to IDLE.
    - Any low sample restarts the count. This is break/line-fault recovery.
- Latency: char_valid asserts 1 cycle after the mid-stop-bit sample, roughly 9.5 bit times plus 3 cycles after the rx falling edge.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit arriving immediately after the stop bit is caught. No idle gap is needed.
- Simultaneous events: char_valid and framing_err are never high in the same cycle.
- Reset mid-frame: partial data is discarded and no pulse is emitted. After release the FSM is in IDLE, and any remaining low bits of the aborted frame may be parsed as a new frame; the consumer tolerates this.
- No backpressure: the consumer must accept one byte per char_valid pulse. Pulses are at least about 10 bit times apart.

Decomposition:
- Shared include uart_defs.vh holds:
  - FSM state localparams (IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4), 3-bit encoding.
  - The CLKS_PER_BIT derivation macro, shared with a future uart_tx.
- One natural sub-module: sync_2ff (parameterised reset value, default 1), instantiated on rx. It is reusable for other async inputs on the board.

Test Plan:
- Timing for all scenarios: bench uses CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16.
- 1. Reset then send 0x55, 8N1 → exactly one char_valid pulse with char_out=0x55; framing_err stays 0; busy returns to 0 after the stop bit.
- 2. Send 0x00 then 0xFF with zero idle between frames → two char_valid pulses, char_out=0x00 then 0xFF, with the pulses 160±1 cycles apart.
- 3. Drive rx low for 4 cycles then high → no char_valid, no framing_err; FSM back in IDLE; a following 0xA5 is received correctly.
- 4. Send 0xA5 with the stop bit forced low, hold rx low for 40 more cycles, then release and idle for 16 cycles, then send 0x3C:
  - framing_err pulses once; char_out keeps its previous value.
  - No reception while rx is low.
  - 0x3C is then received with char_valid=1.
- 5. Pull rst_n low asynchronously (mid-cycle) during data bit 3 of 0x7E → outputs clear immediately. With rx held high for 20 cycles after release, then 0x7E sent → single char_valid with char_out=0x7E.
- 6. Chain into pattern_search (PATTERN_SIZE=10, INFO_SIZE=2): serially send the 10 gold bytes then 0x12, 0x34 → consumer emits info_data 0x12 then 0x34.
